// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : fpu_pkg
// Brief  : Shared FPU constants, flag bit positions and skid-buffer states.
// Rev    : 1.0
// ============================================================================
package fpu_pkg;

    localparam int FLAG_NV  = 4;
    localparam int FLAG_NX  = 0;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] c_INT_MAX      = 32'h7FFF_FFFF;
    localparam logic [31:0] c_UINT_MAX     = 32'hFFFF_FFFF;
    localparam logic [31:0] c_INT_MIN      = 32'h8000_0000;
    localparam logic [31:0] c_FP_NEG_2P31  = 32'hCF00_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

endpackage
`default_nettype wire

// File: rtl/fcvt_flag_gen.sv
`default_nettype none
// ============================================================================
// Module : fcvt_flag_gen
// Brief  : Combinational RISC-V fixup of converter results plus NV/NX flags.
// Rev    : 1.0
// ============================================================================
module fcvt_flag_gen
    import fpu_pkg::*;
#(
    parameter int FLAG_W = 5
) (
    input  logic [31:0]       i_a,
    input  logic              i_signed,
    input  logic              i_to_float,
    input  logic [31:0]       i_cvt_result,
    output logic [31:0]       o_data,
    output logic [FLAG_W-1:0] o_flags
);

    localparam logic [7:0] c_EXP_MAX   = 8'hFF;
    localparam logic [7:0] c_EXP_ONE   = 8'(EXP_BIAS);
    localparam logic [7:0] c_EXP_S_OVF = 8'(EXP_BIAS + 30);
    localparam logic [7:0] c_EXP_U_OVF = 8'(EXP_BIAS + 31);
    localparam logic [7:0] c_EXP_EXACT = 8'(EXP_BIAS + 23);

    logic        w_s;
    logic [7:0]  w_e;
    logic [22:0] w_f;
    logic [7:0]  w_sh;
    logic [23:0] w_fmask;
    logic [31:0] w_m;
    logic [4:0]  w_p;
    logic [31:0] w_mmask;
    logic        w_nv;
    logic        w_nx;

    assign w_s = i_a[31];
    assign w_e = i_a[30:23];
    assign w_f = i_a[22:0];

    // Fraction bits below the binary point when 1.0 <= |x| < 2^23.
    assign w_sh    = c_EXP_EXACT - w_e;
    assign w_fmask = (24'd1 << w_sh) - 24'd1;

    always_comb begin
        w_m = (i_signed && w_s) ? (~i_a + 32'd1) : i_a;
        w_p = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (w_m[i]) w_p = 5'(i);
        end
        w_mmask = (32'd1 << (w_p - 5'd23)) - 32'd1;
    end

    always_comb begin
        o_data = i_cvt_result;
        w_nv   = 1'b0;
        w_nx   = 1'b0;
        if (i_to_float) begin
            if (i_signed && (i_a == c_INT_MIN)) begin
                o_data = c_FP_NEG_2P31;
            end else if (w_p > 5'd23) begin
                w_nx = |(w_m & w_mmask);
            end
        end else if (w_e == c_EXP_MAX) begin
            w_nv = 1'b1;
            if (w_f != 23'd0 || !w_s) o_data = i_signed ? c_INT_MAX : c_UINT_MAX;
            else                      o_data = i_signed ? c_INT_MIN : 32'd0;
        end else if (i_signed && (w_e > c_EXP_S_OVF) && (i_a != c_FP_NEG_2P31)) begin
            w_nv = 1'b1;
        end else if (!i_signed && !w_s && (w_e > c_EXP_U_OVF)) begin
            w_nv = 1'b1;
        end else if (!i_signed && w_s && (w_e >= c_EXP_ONE)) begin
            w_nv   = 1'b1;
            o_data = 32'd0;
        end else if (w_e < c_EXP_ONE) begin
            if (i_a[30:0] != 31'd0) begin
                w_nx   = 1'b1;
                o_data = 32'd0;
            end
        end else if (w_e < c_EXP_EXACT) begin
            w_nx = |(w_f & w_fmask[22:0]);
        end
    end

    always_comb begin
        o_flags          = '0;
        o_flags[FLAG_NV] = w_nv;
        o_flags[FLAG_NX] = w_nx;
    end

endmodule
`default_nettype wire

// File: rtl/fcvt_wb_stage.sv
`default_nettype none
// ============================================================================
// Module : fcvt_wb_stage
// Brief  : Registered FCVT writeback stage with skid buffer and sticky fflags.
// Rev    : 1.0
// ============================================================================
module fcvt_wb_stage
    import fpu_pkg::*;
#(
    parameter int RD_W   = 5,
    parameter int FLAG_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [31:0]       a_i,
    input  logic              op_signed_i,
    input  logic              conv_type_i,
    input  logic [31:0]       cvt_result_i,
    input  logic [RD_W-1:0]   rd_i,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [31:0]       wb_data_o,
    output logic [RD_W-1:0]   wb_rd_o,
    output logic              wb_to_fpr_o,
    output logic [FLAG_W-1:0] wb_flags_o,
    output logic [FLAG_W-1:0] fflags_o,
    input  logic              fflags_clr_i
);

    skid_state_t       r_state;
    logic [31:0]       r_out_data,  r_skid_data;
    logic [RD_W-1:0]   r_out_rd,    r_skid_rd;
    logic              r_out_fpr,   r_skid_fpr;
    logic [FLAG_W-1:0] r_out_flags, r_skid_flags;
    logic [FLAG_W-1:0] r_fflags;

    logic [31:0]       w_data;
    logic [FLAG_W-1:0] w_flags;
    logic              w_accept;
    logic              w_fire;

    fcvt_flag_gen #(
        .FLAG_W (FLAG_W)
    ) u_flag_gen (
        .i_a          (a_i),
        .i_signed     (op_signed_i),
        .i_to_float   (conv_type_i),
        .i_cvt_result (cvt_result_i),
        .o_data       (w_data),
        .o_flags      (w_flags)
    );

    // Handshake signals decode only the state register: wb_ready_i never reaches ready_o.
    assign ready_o    = (r_state != ST_TWO);
    assign wb_valid_o = (r_state != ST_EMPTY);
    assign w_accept   = valid_i && ready_o;
    assign w_fire     = wb_valid_o && wb_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_EMPTY;
            r_out_data   <= '0;
            r_out_rd     <= '0;
            r_out_fpr    <= 1'b0;
            r_out_flags  <= '0;
            r_skid_data  <= '0;
            r_skid_rd    <= '0;
            r_skid_fpr   <= 1'b0;
            r_skid_flags <= '0;
            r_fflags     <= '0;
        end else begin
            r_fflags <= (fflags_clr_i ? '0 : r_fflags) | (w_fire ? r_out_flags : '0);
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_out_data  <= w_data;
                        r_out_rd    <= rd_i;
                        r_out_fpr   <= conv_type_i;
                        r_out_flags <= w_flags;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_fire) begin
                        r_skid_data  <= w_data;
                        r_skid_rd    <= rd_i;
                        r_skid_fpr   <= conv_type_i;
                        r_skid_flags <= w_flags;
                        r_state      <= ST_TWO;
                    end else if (w_fire && !w_accept) begin
                        r_state <= ST_EMPTY;
                    end else if (w_fire && w_accept) begin
                        r_out_data  <= w_data;
                        r_out_rd    <= rd_i;
                        r_out_fpr   <= conv_type_i;
                        r_out_flags <= w_flags;
                    end
                end
                ST_TWO: begin
                    if (w_fire) begin
                        r_out_data  <= r_skid_data;
                        r_out_rd    <= r_skid_rd;
                        r_out_fpr   <= r_skid_fpr;
                        r_out_flags <= r_skid_flags;
                        r_state     <= ST_ONE;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign wb_data_o   = r_out_data;
    assign wb_rd_o     = r_out_rd;
    assign wb_to_fpr_o = r_out_fpr;
    assign wb_flags_o  = r_out_flags;
    assign fflags_o    = r_fflags;

endmodule
`default_nettype wire

// File: doc/fcvt_wb_stage.md
Name: fcvt_wb_stage

Overview:
- Registered writeback stage directly downstream of the combinational float<->int converter in the FPU.
- Captures the converter result together with its operand and control bits.
- Applies the RISC-V special-case result fixups the converter does not handle, and computes the NV/NX exception flags.
- Delivers the result to the register-file writeback port over a valid/ready handshake (full-throughput skid buffer) and accumulates sticky fflags.

Parameters:
- RD_W, 5, width of destination register index.
- FLAG_W, 5, fflags width; bit order {NV,DZ,OF,UF,NX}.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- valid_i  in  1  converter output valid.
- ready_o  out  1  stage can accept.
- a_i  in  32  operand given to the converter.
- op_signed_i  in  1  signed integer side.
- conv_type_i  in  1  1=int->float, 0=float->int.
- cvt_result_i  in  32  converter result.
- rd_i  in  RD_W  destination register.
- wb_valid_o  out  1  writeback valid.
- wb_ready_i  in  1  regfile accepts.
- wb_data_o  out  32  fixed-up result.
- wb_rd_o  out  RD_W  destination register.
- wb_to_fpr_o  out  1  1=float regfile (equals captured conv_type).
- wb_flags_o  out  FLAG_W  flags of the current writeback entry.
- fflags_o  out  FLAG_W  sticky accumulated flags.
- fflags_clr_i  in  1  clear sticky flags.

Behaviour:
- Reset (synchronous, rst_i=1): both entries empty; wb_valid_o=0, wb_data_o=0, wb_rd_o=0, wb_to_fpr_o=0, wb_flags_o=0, fflags_o=0; ready_o=1 in the cycle after reset. Reset mid-transfer drops all entries.
- Storage: output register OUT plus skid register SKID. States EMPTY, ONE, TWO.
  - Input accept = valid_i & ready_o, with ready_o = (state != TWO); registered, no comb path from wb_ready_i.
  - Output fire = wb_valid_o & wb_ready_i; wb_valid_o = (state != EMPTY).
  - EMPTY: accept -> ONE.
  - ONE: accept & !fire -> TWO (new item to SKID); fire & !accept -> EMPTY; both -> ONE (new item to OUT).
  - TWO: fire -> ONE (SKID moves to OUT).
  - Order is strictly FIFO. Latency: 1 cycle from accept to wb_valid_o when empty.
- Fixup and flags are computed combinationally at input and stored with the entry.
- Float->int (conv_type=0): e=a[30:23], f=a[22:0], s=a[31].
  - NaN (e=255, f!=0): data 0x7FFFFFFF signed / 0xFFFFFFFF unsigned; NV.
  - Inf: +inf -> 0x7FFFFFFF / 0xFFFFFFFF; -inf -> 0x80000000 / 0x00000000; NV.
  - Signed overflow: e>157, except a=0xCF000000 (exact -2^31: no NV). Data is cvt_result_i; NV.
  - Unsigned overflow: e>158 and s=0. Data is cvt_result_i; NV.
  - Unsigned, s=1, e>=127: data 0; NV.
  - |x|<1 nonzero (e<127, {e,f}!=0): data 0; NX (both signednesses).
  - 127<=e<=149: NX if low (150-e) bits of f are nonzero.
  - NV suppresses NX. Otherwise data = cvt_result_i.
- Int->float (conv_type=1):
  - m = |a| if signed, else a; p = msb index of m.
  - NX if p>23 and m[p-24:0] != 0.
  - Signed a=0x80000000: data forced to 0xCF000000, no NX.
  - Otherwise data = cvt_result_i (truncation; no rounding here). NV never set.
- DZ/OF/UF are always 0.
- Sticky: fflags_next = (fflags_clr_i ? 0 : fflags_o) | (fire ? wb_flags_o : 0). A clear coinciding with a fire keeps the fired flags.

Decomposition:
- Shared package fpu_pkg:
  - FLAG_NV/NX bit indices, EXP_BIAS=127, canonical constants 0x7FFFFFFF, 0xFFFFFFFF, 0x80000000, 0xCF000000.
  - skid state encoding.
- One sub-module: fcvt_flag_gen (combinational fixup + flag generation).
- The top holds the skid buffer and the sticky register.

Test Plan:
- Float->int signed, a=0x40490FDB, cvt=3, wb_ready_i=1 -> next cycle wb_data_o=3, wb_flags_o=0x01, fflags_o=0x01 after fire.
- Float->int unsigned, a=0xBF800000 (-1.0), cvt=1 -> wb_data_o=0, wb_flags_o=0x10; a=0xBF000000 (-0.5) -> data 0, flags 0x01.
- NaN and bounds:
  - a=0x7FC00000 signed -> 0x7FFFFFFF, flags 0x10.
  - a=0xCF000000 signed -> 0x80000000, flags 0.
  - a=0x4F000000 signed -> flags 0x10.
- Int->float:
  - a=0x01000001 unsigned, cvt=0x4B800000 -> data 0x4B800000, flags 0x01.
  - a=0x80000000 signed -> 0xCF000000, flags 0.
- Backpressure: wb_ready_i=0 while 3 back-to-back valid_i -> two accepted, ready_o=0 on the third; release wb_ready_i -> outputs in order, no loss or duplication.
- fflags_clr_i asserted in the same cycle as a fire with NX -> fflags_o=0x01. rst_i asserted in TWO state -> next cycle wb_valid_o=0, fflags_o=0, ready_o=1.
